// File: rtl/irq_controller_if.sv
// Peribus register-access bundle shared by the peripherals.
//   addr        : 2-bit register address
//   write_data  : 16-bit write data
//   write_en    : write strobe (qualified by chipselect)
//   read_en     : read strobe (qualified by chipselect)
//   chipselect  : peripheral select
//   read_data   : 16-bit registered read data returned by the peripheral
interface irq_controller_if;
    logic [1:0]  addr;
    logic [15:0] write_data;
    logic        write_en;
    logic        read_en;
    logic        chipselect;
    logic [15:0] read_data;

    modport master (
        output addr, write_data, write_en, read_en, chipselect,
        input  read_data
    );

    modport slave (
        input  addr, write_data, write_en, read_en, chipselect,
        output read_data
    );
endinterface

// File: rtl/irq_controller.sv
// Peribus interrupt controller.
// Collects NUM_IRQ peripheral interrupt lines into a pending register, masks
// them with ENABLE, and presents one prioritised request to the CPU. Software
// claims the lowest-index active source by reading the VECTOR register and
// releases the controller by writing EOI.
// Ports:
//   clock   : system clock, rising edge
//   reset   : synchronous active-high reset
//   bus     : Peribus slave (addr/write_data/write_en/read_en/chipselect/read_data)
//   irq_in  : peripheral interrupt lines, synchronous to clock
//   cpu_irq : registered interrupt request to the CPU
// Registers: 0 PENDING (W1C), 1 ENABLE, 2 MODE (1 = edge, 0 = level),
//            3 VECTOR/CTRL (read {valid, global_en, 10'h0, idx}; write bit14
//            global_en, bit15 EOI).
module irq_controller #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clock,
    input  logic               reset,
    irq_controller_if.slave    bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               cpu_irq
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] enable_r;
    logic [NUM_IRQ-1:0] mode_r;
    logic [NUM_IRQ-1:0] prev_in_r;
    logic               global_en_r;
    logic [1:0]         state_r;
    logic [3:0]         svc_idx_r;
    logic [15:0]        read_data_r;
    logic               cpu_irq_r;

    logic               rd_s;
    logic               wr_s;
    logic               rd_vec_s;
    logic               wr_vec_s;
    logic [NUM_IRQ-1:0] active_s;
    logic [3:0]         winner_s;
    logic               claim_s;
    logic               eoi_s;
    logic [1:0]         state_nxt_s;
    logic [NUM_IRQ-1:0] set_s;
    logic [NUM_IRQ-1:0] w1c_s;
    logic [NUM_IRQ-1:0] eoi_clr_s;
    logic [NUM_IRQ-1:0] pending_nxt_s;
    logic [15:0]        rdata_nxt_s;

    // Zero-extend a per-source vector to the 16-bit register width.
    function automatic logic [15:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < NUM_IRQ; i++) begin
            r[i] = v[i];
        end
        return r;
    endfunction

    // Index of the lowest set bit (highest priority); 0 when none set.
    function automatic logic [3:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = 4'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Bus decode, priority selection and FSM next-state.
    always_comb begin
        rd_s        = bus.chipselect && bus.read_en;
        wr_s        = bus.chipselect && bus.write_en;
        rd_vec_s    = rd_s && (bus.addr == 2'd3);
        wr_vec_s    = wr_s && (bus.addr == 2'd3);
        active_s    = pending_r & enable_r;
        winner_s    = lowest_idx(active_s);
        claim_s     = 1'b0;
        eoi_s       = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (global_en_r && (|active_s)) begin
                    state_nxt_s = ST_ASSERT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                // Losing the request takes precedence over a claim in the same cycle.
                if (!global_en_r || !(|active_s)) begin
                    state_nxt_s = ST_IDLE;
                end else if (rd_vec_s) begin
                    claim_s     = 1'b1;
                    state_nxt_s = ST_SERVICE;
                end else begin
                    state_nxt_s = ST_ASSERT;
                end
            end
            ST_SERVICE: begin
                // Only EOI leaves service; disabling the source does not abort it.
                if (wr_vec_s && bus.write_data[15]) begin
                    eoi_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pending next-state: clears first, then sets, so a new event wins over W1C/EOI.
    always_comb begin
        set_s     = irq_in & ~(mode_r & prev_in_r);
        w1c_s     = {NUM_IRQ{1'b0}};
        eoi_clr_s = {NUM_IRQ{1'b0}};
        if (wr_s && (bus.addr == 2'd0)) begin
            w1c_s = bus.write_data[NUM_IRQ-1:0];
        end else begin
            w1c_s = {NUM_IRQ{1'b0}};
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            eoi_clr_s[i] = eoi_s && (svc_idx_r == 4'(i));
        end
        pending_nxt_s = (pending_r & ~(w1c_s | eoi_clr_s)) | set_s;
    end

    // Read-data multiplexer.
    always_comb begin
        rdata_nxt_s = 16'h0000;
        case (bus.addr)
            2'd0: rdata_nxt_s = zext(pending_r);
            2'd1: rdata_nxt_s = zext(enable_r);
            2'd2: rdata_nxt_s = zext(mode_r);
            2'd3: begin
                if (state_r == ST_SERVICE) begin
                    rdata_nxt_s = {1'b1, global_en_r, 10'h000, svc_idx_r};
                end else if (claim_s) begin
                    rdata_nxt_s = {1'b1, global_en_r, 10'h000, winner_s};
                end else begin
                    rdata_nxt_s = {1'b0, global_en_r, 14'h0000};
                end
            end
            default: rdata_nxt_s = 16'h0000;
        endcase
    end

    // Interrupt state: pending, edge history, FSM and CPU request.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r <= {NUM_IRQ{1'b0}};
            prev_in_r <= {NUM_IRQ{1'b0}};
            state_r   <= ST_IDLE;
            svc_idx_r <= 4'd0;
            cpu_irq_r <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            prev_in_r <= irq_in;
            state_r   <= state_nxt_s;
            cpu_irq_r <= (state_r == ST_ASSERT);
            if (claim_s) begin
                svc_idx_r <= winner_s;
            end
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_r    <= {NUM_IRQ{1'b0}};
            mode_r      <= {NUM_IRQ{1'b0}};
            global_en_r <= 1'b0;
        end else begin
            if (wr_s && (bus.addr == 2'd1)) begin
                enable_r <= bus.write_data[NUM_IRQ-1:0];
            end
            if (wr_s && (bus.addr == 2'd2)) begin
                mode_r <= bus.write_data[NUM_IRQ-1:0];
            end
            // bit14 applies in every state, even when the EOI bit is ignored.
            if (wr_vec_s) begin
                global_en_r <= bus.write_data[14];
            end
        end
    end

    // Registered read data; holds when no read is strobed.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_r <= 16'h0000;
        end else if (rd_s) begin
            read_data_r <= rdata_nxt_s;
        end
    end

    assign bus.read_data = read_data_r;
    assign cpu_irq       = cpu_irq_r;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int NUM_IRQ = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_in;
    logic               cpu_irq;

    irq_controller_if bus_if ();

    irq_controller #(.NUM_IRQ(NUM_IRQ)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus_if),
        .irq_in  (irq_in),
        .cpu_irq (cpu_irq)
    );

    always #5 clock = ~clock;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic        rd_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_en   = 1'b1;
        bus_if.addr       = a;
        bus_if.write_data = d;
        @(negedge clock);
        bus_if.chipselect = 1'b0;
        bus_if.write_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [15:0] exp, input string tag);
        bus_if.chipselect = 1'b1;
        bus_if.read_en    = 1'b1;
        bus_if.addr       = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clock);
        bus_if.chipselect = 1'b0;
        bus_if.read_en    = 1'b0;
    endtask

    // One-cycle pulse on the selected lines.
    task automatic pulse(input logic [NUM_IRQ-1:0] m);
        irq_in = m;
        @(negedge clock);
        irq_in = '0;
    endtask

    // Note which edges captured a read strobe.
    always @(posedge clock) rd_seen <= bus_if.chipselect && bus_if.read_en;

    // Scoreboard: compare each returned read against the queued expectation.
    always @(negedge clock) begin
        if (rd_seen) begin
            check_eq("sb_has_entry", 16'(exp_q.size() != 0), 16'h0001);
            if (exp_q.size() != 0) begin
                check_eq(tag_q.pop_front(), bus_if.read_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        irq_in            = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_en   = 1'b0;
        bus_if.read_en    = 1'b0;
        bus_if.addr       = 2'd0;
        bus_if.write_data = 16'h0000;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        bus_read(2'd0, 16'h0000, "rst_pending");
        bus_read(2'd1, 16'h0000, "rst_enable");
        bus_read(2'd2, 16'h0000, "rst_mode");
        bus_read(2'd3, 16'h0000, "rst_vector");
        check_eq("rst_cpu_irq", 16'(cpu_irq), 16'h0000);

        // Single edge source: timing of cpu_irq, claim, EOI
        bus_write(2'd1, 16'h0001);
        bus_write(2'd2, 16'h0001);
        bus_write(2'd3, 16'h4000);
        pulse(8'h01);
        check_eq("t2_irq_c0", 16'(cpu_irq), 16'h0000);
        tick(1);
        check_eq("t2_irq_c1", 16'(cpu_irq), 16'h0000);
        tick(1);
        check_eq("t2_irq_c2", 16'(cpu_irq), 16'h0001);
        bus_read(2'd0, 16'h0001, "t2_pending");
        bus_read(2'd3, 16'hC000, "t2_claim");
        tick(1);
        check_eq("t2_irq_svc", 16'(cpu_irq), 16'h0000);
        bus_read(2'd3, 16'hC000, "t2_svc_vec");
        bus_write(2'd3, 16'h8000);
        bus_read(2'd0, 16'h0000, "t2_pend_eoi");
        bus_read(2'd3, 16'h0000, "t2_idle_vec");

        // Two edge sources: priority order 2 then 5
        bus_write(2'd1, 16'h0024);
        bus_write(2'd2, 16'h0024);
        bus_write(2'd3, 16'h4000);
        pulse(8'h24);
        tick(3);
        check_eq("t3_irq", 16'(cpu_irq), 16'h0001);
        bus_read(2'd3, 16'hC002, "t3_claim2");
        bus_write(2'd3, 16'hC000);
        tick(1);
        check_eq("t3_irq_eoi1", 16'(cpu_irq), 16'h0000);
        tick(1);
        check_eq("t3_irq_eoi2", 16'(cpu_irq), 16'h0001);
        bus_read(2'd3, 16'hC005, "t3_claim5");
        bus_write(2'd3, 16'hC000);
        bus_read(2'd0, 16'h0000, "t3_pend_done");

        // Level source held across EOI: set wins over the EOI clear
        bus_write(2'd2, 16'h0000);
        bus_write(2'd1, 16'h0001);
        irq_in = 8'h01;
        tick(3);
        check_eq("t4_irq", 16'(cpu_irq), 16'h0001);
        bus_read(2'd3, 16'hC000, "t4_claim");
        bus_write(2'd3, 16'hC000);
        check_eq("t4_irq_eoi0", 16'(cpu_irq), 16'h0000);
        tick(1);
        check_eq("t4_irq_eoi1", 16'(cpu_irq), 16'h0000);
        tick(1);
        check_eq("t4_irq_eoi2", 16'(cpu_irq), 16'h0001);
        bus_read(2'd0, 16'h0001, "t4_pend_held");
        irq_in = 8'h00;
        tick(1);
        bus_write(2'd0, 16'h0001);
        bus_read(2'd0, 16'h0000, "t4_pend_w1c");

        // W1C of the only source while in ASSERT drops the request
        bus_write(2'd2, 16'h0001);
        tick(2);
        pulse(8'h01);
        tick(2);
        check_eq("t5_irq", 16'(cpu_irq), 16'h0001);
        bus_write(2'd0, 16'h0001);
        tick(2);
        check_eq("t5_irq_drop", 16'(cpu_irq), 16'h0000);
        bus_read(2'd3, 16'h4000, "t5_vec_idle");

        // Reset during SERVICE, then level source with enable = 0
        bus_write(2'd1, 16'h0003);
        bus_write(2'd2, 16'h0003);
        pulse(8'h03);
        tick(3);
        bus_read(2'd3, 16'hC000, "t6_claim");
        bus_read(2'd0, 16'h0003, "t6_pending");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("t6_rst_irq", 16'(cpu_irq), 16'h0000);
        check_eq("t6_rst_rdata", bus_if.read_data, 16'h0000);
        bus_read(2'd0, 16'h0000, "t6_rst_pend");
        bus_read(2'd1, 16'h0000, "t6_rst_en");
        bus_read(2'd2, 16'h0000, "t6_rst_mode");
        bus_read(2'd3, 16'h0000, "t6_rst_vec");
        pulse(8'h02);
        tick(3);
        check_eq("t6_irq_masked", 16'(cpu_irq), 16'h0000);
        bus_read(2'd0, 16'h0002, "t6_pend_masked");

        tick(2);
        check_eq("sb_drained", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Peribus interrupt controller that collects peripheral interrupt lines and presents one prioritised, acknowledged interrupt to the CPU. The TIMER irq drives irq_in[0], and other peripherals drive the higher indices. Software reads a vector register to claim the highest-priority source. It then writes end-of-interrupt (EOI) to release the controller. Register reads and writes use the same 2-bit-address Peribus protocol as the other peripherals.

Parameters:
NUM_IRQ, 8, number of interrupt inputs; legal range 1..16; index 0 has the highest priority.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
addr  input  2  Peribus register address.
write_data  input  16  Peribus write data.
write_en  input  1  Peribus write strobe.
read_en  input  1  Peribus read strobe.
chipselect  input  1  peripheral select; qualifies write_en and read_en.
read_data  output  16  registered read data.
irq_in  input  NUM_IRQ  peripheral interrupt lines, synchronous to clock.
cpu_irq  output  1  registered interrupt request to the CPU.

Behaviour:
- Register map; bits at and above NUM_IRQ read as 0 and ignore writes:
  - 0 PENDING: write-1-to-clear.
  - 1 ENABLE: read/write mask.
  - 2 MODE: per source, 1 = rising-edge, 0 = level.
  - 3 VECTOR/CTRL:
    - Read returns {valid[15], global_en[14], 10'h0, idx[3:0]}.
    - Write: bit14 sets global_en; bit15 = EOI.
- Reset: pending, enable, mode, global_en, prev_in, read_data and cpu_irq all go to 0; state = IDLE; in-service index = 0.
- Reads: when chipselect && read_en, read_data is loaded on the next edge (1-cycle latency). With no read, read_data holds its value.
- Writes: take effect on the edge where chipselect && write_en.
- Edge detect: prev_in <= irq_in every cycle. An edge-mode source sets pending[i] when irq_in[i] && !prev_in[i].
- Level mode: pending[i] is set on every cycle that irq_in[i] is 1.
- Set and clear in the same cycle: set wins, for both W1C and EOI clear.
- Candidate vector: active = pending & enable. Winner = lowest set index of active.
- Interrupt FSM states:
  - IDLE:
    - Go to ASSERT when global_en && |active.
    - cpu_irq = 0.
  - ASSERT:
    - cpu_irq = 1 (registered, so it rises the cycle after entering ASSERT).
    - If active becomes 0 or global_en becomes 0, return to IDLE; cpu_irq drops next cycle.
    - On a read of addr 3: latch the winner as svc_idx; read_data = {1, global_en, 10'h0, winner}; go to SERVICE.
  - SERVICE:
    - cpu_irq = 0.
    - A read of addr 3 returns {1, global_en, 0, svc_idx}.
    - A write to addr 3 with bit15 = 1 clears pending[svc_idx] and returns to IDLE.
    - A re-pending source raises cpu_irq again at the earliest 2 cycles after the EOI write.
- A read of addr 3 in IDLE returns valid = 0, idx = 0, and the state is unchanged.
- An EOI written in IDLE or ASSERT is ignored, but bit14 is still applied.
- Claim races: a higher-priority source arriving on the same cycle as the vector read is not claimed. The winner is taken from the pending state before that edge.
- Claim with global_en = 0: not possible, since ASSERT exits when global_en is 0.
- Disabling a source while it is in SERVICE does not abort the service; EOI is still required.

Test Plan:
- Reset, then read addrs 0-3 -> all 0x0000. cpu_irq = 0.
- ENABLE = 0x0001, MODE = 0x0001, CTRL = 0x4000. Pulse irq_in[0] for 1 cycle -> PENDING = 0x0001, cpu_irq = 1 two cycles after the pulse. Read addr 3 -> 0xC000, cpu_irq = 0. Write 0x8000 to addr 3 -> PENDING = 0x0000, state IDLE.
- Sources 2 and 5 pending and enabled, edge mode -> vector read gives idx 2. EOI -> cpu_irq re-asserts, next vector read gives idx 5.
- Level-mode irq_in[0] held high across EOI -> PENDING bit0 stays 1, cpu_irq re-asserts 2 cycles after EOI. Drop irq_in[0], write 0x0001 to addr 0 -> PENDING = 0.
- In ASSERT, write 0x0001 to addr 0 (the only source) -> next cycle IDLE, cpu_irq = 0. A vector read now returns 0x4000 (valid = 0).
- Assert reset while in SERVICE with pending = 0x0003 -> next cycle all registers 0, cpu_irq = 0, state IDLE. Edge on irq_in[1] with enable = 0 -> PENDING bit1 = 1, cpu_irq stays 0.
